// File: rtl/controle_rodada_pkg.sv
// Shared game definitions: 4-bit state codes exposed on the debug port.
package controle_rodada_pkg;

  typedef enum logic [3:0] {
    StInicial   = 4'd0,
    StPrepara   = 4'd1,
    StMostra    = 4'd2,
    StFimMostra = 4'd3,
    StEspera    = 4'd4,
    StFimRodada = 4'd5,
    StVitoria   = 4'd6,
    StErro      = 4'd7,
    StEsgotou   = 4'd8
  } estado_e;

endpackage

// File: rtl/controle_rodada_if.sv
// Signals between the game FSM/buttons, the move counter datapath and controle_rodada.
interface controle_rodada_if #(
  parameter int unsigned N = 6
) ();
  logic         iniciar;
  logic         jogada_valida;
  logic         jogada_igual;
  logic [N-1:0] jog_q;
  logic         jog_fim;
  logic         zera_jog;
  logic         conta_jog;
  logic         mostra;
  logic [N-1:0] rodada;
  logic         pronto;
  logic         acertou;
  logic         errou;
  logic         timeout;
  logic [3:0]   estado;

  modport master (
    output iniciar, jogada_valida, jogada_igual, jog_q, jog_fim,
    input  zera_jog, conta_jog, mostra, rodada, pronto, acertou, errou, timeout, estado
  );

  modport slave (
    input  iniciar, jogada_valida, jogada_igual, jog_q, jog_fim,
    output zera_jog, conta_jog, mostra, rodada, pronto, acertou, errou, timeout, estado
  );
endinterface

// File: rtl/controle_rodada_temporizador.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module controle_rodada_temporizador #(
  parameter int unsigned TW = 13
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] valor
);

  logic [TW-1:0] valor_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valor_q <= '0;
    end else if (clr) begin
      valor_q <= '0;
    end else if (en && (valor_q != '1)) begin
      valor_q <= valor_q + 1'b1;
    end
  end

  assign valor = valor_q;

endmodule

// File: rtl/controle_rodada.sv
// Round sequencer: shows moves 0..rodada, then checks the player's moves with a timeout.
module controle_rodada
  import controle_rodada_pkg::*;
#(
  parameter int unsigned M        = 32,
  parameter int unsigned N        = 6,
  parameter int unsigned T_MOSTRA = 500,
  parameter int unsigned T_LIMITE = 5000,
  parameter int unsigned TW       = 13
) (
  input logic            clock,
  input logic            rst_n,
  controle_rodada_if.slave bus
);

  localparam logic [TW-1:0] AlvoMostra = TW'(T_MOSTRA - 1);
  localparam logic [TW-1:0] AlvoLimite = TW'(T_LIMITE - 1);
  localparam logic [N-1:0]  RodadaMax  = N'(M);

  estado_e       estado_q, estado_d;
  logic [N-1:0]  rodada_q, rodada_d;
  logic [TW-1:0] tempo;
  logic          tmr_clr, tmr_en, expira, ultimo, conta;
  logic          unused_jog_fim;

  assign unused_jog_fim = bus.jog_fim;

  controle_rodada_temporizador #(
    .TW(TW)
  ) u_temporizador (
    .clock(clock),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .valor(tempo)
  );

  // One timer serves both the display dwell and the player timeout.
  assign expira = (tempo == ((estado_q == StMostra) ? AlvoMostra : AlvoLimite));
  assign ultimo = (bus.jog_q == rodada_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= StInicial;
      rodada_q <= '0;
    end else begin
      estado_q <= estado_d;
      rodada_q <= rodada_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    rodada_d = rodada_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    conta    = 1'b0;
    unique case (estado_q)
      StInicial: begin
        if (bus.iniciar) estado_d = StPrepara;
      end
      StPrepara: begin
        rodada_d = '0;
        tmr_clr  = 1'b1;
        estado_d = StMostra;
      end
      StMostra: begin
        tmr_en = 1'b1;
        if (expira) begin
          if (ultimo) begin
            estado_d = StFimMostra;
          end else begin
            conta   = 1'b1;
            tmr_clr = 1'b1;
          end
        end
      end
      StFimMostra: begin
        tmr_clr  = 1'b1;
        estado_d = StEspera;
      end
      StEspera: begin
        tmr_en = 1'b1;
        // A move on the expiry cycle takes priority over the timeout.
        if (bus.jogada_valida) begin
          if (!bus.jogada_igual) begin
            estado_d = StErro;
          end else if (ultimo) begin
            estado_d = StFimRodada;
          end else begin
            conta   = 1'b1;
            tmr_clr = 1'b1;
          end
        end else if (expira) begin
          estado_d = StEsgotou;
        end
      end
      StFimRodada: begin
        if (rodada_q == RodadaMax) begin
          estado_d = StVitoria;
        end else begin
          rodada_d = rodada_q + 1'b1;
          tmr_clr  = 1'b1;
          estado_d = StMostra;
        end
      end
      StVitoria, StErro, StEsgotou: begin
        if (bus.iniciar) estado_d = StPrepara;
      end
      default: estado_d = StInicial;
    endcase
  end

  // Clear drives the counter's async reset, so it depends on registers only.
  assign bus.zera_jog  = (estado_q == StPrepara) || (estado_q == StFimMostra) ||
                         ((estado_q == StFimRodada) && (rodada_q != RodadaMax));
  assign bus.conta_jog = conta;
  assign bus.mostra    = (estado_q == StMostra);
  assign bus.rodada    = rodada_q;
  assign bus.acertou   = (estado_q == StVitoria);
  assign bus.errou     = (estado_q == StErro);
  assign bus.timeout   = (estado_q == StEsgotou);
  assign bus.pronto    = bus.acertou || bus.errou || bus.timeout;
  assign bus.estado    = estado_q;

endmodule

// File: tb/tb_controle_rodada.sv
// Randomized game-level bench for controle_rodada with a move counter attached.
module tb_controle_rodada;

  localparam int unsigned M        = 3;
  localparam int unsigned N        = 2;
  localparam int unsigned T_MOSTRA = 4;
  localparam int unsigned T_LIMITE = 10;
  localparam int unsigned TW       = 4;

  localparam int EST_VITORIA = 6;
  localparam int EST_ERRO    = 7;
  localparam int EST_ESGOTOU = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  controle_rodada_if #(.N(N)) bus ();

  controle_rodada #(
    .M       (M),
    .N       (N),
    .T_MOSTRA(T_MOSTRA),
    .T_LIMITE(T_LIMITE),
    .TW      (TW)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Move counter: async clear from zera_jog, counts on conta_jog.
  logic [N-1:0] jq;
  always_ff @(posedge clock or posedge bus.zera_jog or negedge rst_n) begin
    if (!rst_n)            jq <= '0;
    else if (bus.zera_jog) jq <= '0;
    else if (bus.conta_jog) jq <= jq + 1'b1;
  end
  assign bus.jog_q   = jq;
  assign bus.jog_fim = (jq == N'(M));

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic confere_zerado(input string tag);
    checa({tag, "_estado"}, 32'(bus.estado), 32'(0));
    checa({tag, "_rodada"}, 32'(bus.rodada), 32'(0));
    checa({tag, "_saidas"}, 32'({bus.zera_jog, bus.conta_jog, bus.mostra, bus.pronto,
                                 bus.acertou, bus.errou, bus.timeout}), 32'(0));
  endtask

  task automatic confere_terminal(input int st, input string tag);
    checa({tag, "_estado"}, 32'(bus.estado), 32'(st));
    checa({tag, "_flags"},
          32'({bus.pronto, bus.acertou, bus.errou, bus.timeout,
               bus.zera_jog, bus.mostra, bus.conta_jog}),
          32'({1'b1, st == EST_VITORIA, st == EST_ERRO, st == EST_ESGOTOU, 3'b000}));
  endtask

  // Called mid-cycle in an idle or terminal state; returns at the start of the first display cycle.
  task automatic inicia();
    bus.iniciar       = 1'b1;
    bus.jogada_valida = 1'b0;
    ciclo();
    bus.iniciar = 1'b0;
    #1;
    checa("prepara_estado", 32'(bus.estado), 32'(1));
    checa("prepara_zera", 32'(bus.zera_jog), 32'(1));
    checa("prepara_mostra", 32'(bus.mostra), 32'(0));
    ciclo();
  endtask

  task automatic mostra_rodada(input int r);
    for (int m = 0; m <= r; m++) begin
      for (int t = 0; t < int'(T_MOSTRA); t++) begin
        bus.iniciar       = 1'($urandom_range(0, 1));
        bus.jogada_valida = 1'($urandom_range(0, 1));
        bus.jogada_igual  = 1'($urandom_range(0, 1));
        #1;
        checa("mostra_estado", 32'(bus.estado), 32'(2));
        checa("mostra_flag", 32'(bus.mostra), 32'(1));
        checa("mostra_jog_q", 32'(bus.jog_q), 32'(m));
        checa("mostra_rodada", 32'(bus.rodada), 32'(r));
        checa("mostra_conta", 32'(bus.conta_jog), 32'(t == int'(T_MOSTRA) - 1 && m != r));
        checa("mostra_zera", 32'(bus.zera_jog), 32'(0));
        ciclo();
      end
    end
    bus.iniciar       = 1'b0;
    bus.jogada_valida = 1'b0;
    #1;
    checa("fim_mostra_estado", 32'(bus.estado), 32'(3));
    checa("fim_mostra_zera", 32'(bus.zera_jog), 32'(1));
    ciclo();
  endtask

  task automatic espera_rodada(input int r, input int er, input int em, input int tr,
                               input int tm, input bit limite, output bit fim);
    fim = 1'b0;
    for (int m = 0; m <= r; m++) begin
      int d;
      bit igual;
      igual = !(r == er && m == em);
      if (r == tr && m == tm) d = int'(T_LIMITE);
      else if (limite)        d = int'(T_LIMITE) - 1;
      else                    d = int'($urandom_range(0, T_LIMITE - 1));
      for (int c = 0; c <= d; c++) begin
        if (c == d) begin
          bus.jogada_valida = 1'b1;
          bus.jogada_igual  = igual;
          #1;
          checa("espera_estado", 32'(bus.estado), 32'(4));
          checa("espera_jog_q", 32'(bus.jog_q), 32'(m));
          checa("espera_rodada", 32'(bus.rodada), 32'(r));
          checa("jogada_conta", 32'(bus.conta_jog), 32'(igual && m != r));
          ciclo();
          bus.jogada_valida = 1'b0;
          bus.jogada_igual  = 1'($urandom_range(0, 1));
          if (!igual) begin
            #1;
            confere_terminal(EST_ERRO, "erro");
            fim = 1'b1;
            return;
          end
        end else begin
          bus.jogada_valida = 1'b0;
          bus.jogada_igual  = 1'($urandom_range(0, 1));
          #1;
          checa("espera_estado", 32'(bus.estado), 32'(4));
          checa("espera_conta", 32'(bus.conta_jog), 32'(0));
          if (c == int'(T_LIMITE) - 1) begin
            ciclo();
            #1;
            confere_terminal(EST_ESGOTOU, "esgotou");
            fim = 1'b1;
            return;
          end
          ciclo();
        end
      end
    end
    #1;
    checa("fim_rodada_estado", 32'(bus.estado), 32'(5));
    checa("fim_rodada_zera", 32'(bus.zera_jog), 32'(r != int'(M)));
    ciclo();
    if (r == int'(M)) begin
      #1;
      confere_terminal(EST_VITORIA, "vitoria");
      fim = 1'b1;
    end
  endtask

  task automatic jogo(input int er, input int em, input int tr, input int tm, input bit limite,
                      input int st_final);
    bit fim;
    fim = 1'b0;
    inicia();
    for (int r = 0; r <= int'(M); r++) begin
      mostra_rodada(r);
      espera_rodada(r, er, em, tr, tm, limite, fim);
      if (fim) break;
    end
    checa("jogo_final", 32'(bus.estado), 32'(st_final));
    // Terminal flags hold; player moves are ignored here.
    for (int k = 0; k < 3; k++) begin
      ciclo();
      bus.jogada_valida = 1'($urandom_range(0, 1));
      #1;
      confere_terminal(st_final, "segura");
    end
    bus.jogada_valida = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed %0d expected %0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int modo, er, em, tr, tm, st;
    bus.iniciar       = 1'b0;
    bus.jogada_valida = 1'b0;
    bus.jogada_igual  = 1'b0;
    #2;
    confere_zerado("reset");
    #10 rst_n = 1'b1;
    ciclo();
    #1;
    checa("ocioso_estado", 32'(bus.estado), 32'(0));

    jogo(-1, -1, -1, -1, 1'b0, EST_VITORIA);
    jogo(2, 1, -1, -1, 1'b0, EST_ERRO);
    jogo(-1, -1, 0, 0, 1'b0, EST_ESGOTOU);
    jogo(-1, -1, -1, -1, 1'b1, EST_VITORIA);
    jogo(-1, -1, 2, 2, 1'b1, EST_ESGOTOU);

    // Asynchronous reset in the middle of the display phase.
    inicia();
    ciclo();
    #3;
    rst_n = 1'b0;
    #1;
    confere_zerado("reset_mostra");
    ciclo();
    rst_n = 1'b1;
    #1;
    checa("pos_reset_estado", 32'(bus.estado), 32'(0));
    ciclo();
    #1;
    confere_zerado("pos_reset_ocioso");

    for (int g = 0; g < 8; g++) begin
      modo = int'($urandom_range(0, 2));
      er = -1; em = -1; tr = -1; tm = -1;
      st = EST_VITORIA;
      if (modo == 1) begin
        er = int'($urandom_range(0, M));
        em = int'($urandom_range(0, er));
        st = EST_ERRO;
      end else if (modo == 2) begin
        tr = int'($urandom_range(0, M));
        tm = int'($urandom_range(0, tr));
        st = EST_ESGOTOU;
      end
      jogo(er, em, tr, tm, 1'($urandom_range(0, 1)), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_rodada.md
# controle_rodada

Sequencing controller for the memory game's move counter (`contador_jogadas`). Each round has a round limit, `rodada`.
- Display phase: steps the move counter through moves 0..`rodada`, dwelling a fixed time on each.
- Input phase: re-arms the counter, then checks each player move against the datapath comparison.
- Ends in win, error or timeout.
- Sits between the top-level game FSM/user buttons and the move counter + sequence memory datapath.

## Interface
Parameters:
- `M`, 32: index of the last move; must equal the move counter's `M`.
- `N`, 6: width of move index and `rodada`; must equal the move counter's `N`.
- `T_MOSTRA`, 500: display dwell per move, in cycles (≥2).
- `T_LIMITE`, 5000: max cycles between player moves before timeout (≥2).
- `TW`, 13: timer width; must hold `max(T_MOSTRA, T_LIMITE)`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start-game pulse.
- `jogada_valida`  in  1  one-cycle pulse: player entered a move.
- `jogada_igual`  in  1  datapath: player move == memory[`jog_q`]; valid when `jogada_valida`=1.
- `jog_q`  in  N  move counter value Q.
- `jog_fim`  in  1  move counter fim (Q==M); informational only.
- `zera_jog`  out  1  move counter clear; drives the counter's async `rst`.
- `conta_jog`  out  1  move counter increment enable.
- `mostra`  out  1  display phase active; display shows memory[`jog_q`].
- `rodada`  out  N  current round limit (round moves = `rodada`+1).
- `pronto`  out  1  game over (any terminal state).
- `acertou`, `errou`, `timeout`  out  1 each  terminal cause.
- `estado`  out  4  state code, for debug.

## Operation
State codes:
- `INICIAL`=0: idle. `iniciar` → `PREPARA`.
- `PREPARA`=1: `zera_jog`=1; `rodada`←0; timer←0 → `MOSTRA`.
- `MOSTRA`=2: `mostra`=1; timer increments. When timer==`T_MOSTRA`-1:
  - if `jog_q`==`rodada` → `FIM_MOSTRA`;
  - else `conta_jog`=1, timer←0, stay.
- `FIM_MOSTRA`=3: `zera_jog`=1; timer←0 → `ESPERA`.
- `ESPERA`=4: timer increments.
  - `jogada_valida` & !`jogada_igual` → `ERRO`.
  - `jogada_valida` & `jogada_igual` & `jog_q`==`rodada` → `FIM_RODADA`.
  - `jogada_valida` & `jogada_igual` otherwise → `conta_jog`=1, timer←0, stay.
  - No `jogada_valida` and timer==`T_LIMITE`-1 → `ESGOTOU`.
- `FIM_RODADA`=5:
  - if `rodada`==M → `VITORIA`;
  - else `rodada`←`rodada`+1, `zera_jog`=1, timer←0 → `MOSTRA`.
- `VITORIA`=6 (`acertou`=1), `ERRO`=7 (`errou`=1), `ESGOTOU`=8 (`timeout`=1): terminal, `pronto`=1. `iniciar` → `PREPARA`.

Output rules:
- `zera_jog` is decoded from the state register only (`PREPARA`, `FIM_MOSTRA`, and `FIM_RODADA` when `rodada`≠M). No input terms, so it is glitch-free on the async clear.
- `conta_jog` is Mealy; the counter samples it on the same edge as the FSM transition.
- `iniciar` is ignored outside `INICIAL` and the terminal states.
- `jogada_valida` is ignored outside `ESPERA`.
- Timer saturates at 2^TW-1; `rodada` never exceeds M (no wrap).

## Timing
- Reset: state=`INICIAL`, `rodada`=0, timer=0, all outputs 0 (`estado`=0), asserted immediately and asynchronously.
- Reset mid-game returns to `INICIAL`. Counter re-clear happens at the next `PREPARA`.
- `iniciar` at edge k: `PREPARA` during cycle k+1, `MOSTRA` from k+2.
- Display: each move held exactly `T_MOSTRA` cycles. Round r display lasts (r+1)·`T_MOSTRA` cycles, followed by 1 cycle of `FIM_MOSTRA`.
- Player move accepted in the same cycle as `jogada_valida`. `jog_q` is updated on the following cycle.
- Timeout fires on the `T_LIMITE`-th consecutive cycle in `ESPERA` without `jogada_valida`. The timer restarts after each accepted move.
- `jogada_valida` on the timeout cycle: the move has priority; no timeout.
- Terminal flags hold until `iniciar` or reset.

## Structure
- Shared game package/include (`jogo_pkg`): 4-bit state codes, with `estado` encoding identical to the codes above.
- One sub-module, `temporizador`: TW-bit up-counter with synchronous clear, enable and saturation. It is used for both the dwell and the timeout limit, with the compare value muxed by state.
- FSM: state register plus next-state/output logic. `rodada` register is local.

## Test plan
Bench uses `M`=3, `T_MOSTRA`=4, `T_LIMITE`=10, with the real move counter attached.
- Reset, then `iniciar` → `PREPARA` 1 cycle, `mostra`=1 for 4 cycles with `jog_q`=0, then `FIM_MOSTRA`, then `ESPERA`.
- Full correct game (`jogada_igual`=1 every move) → rounds 0..3 display 1, 2, 3, 4 moves; after the 4th correct move of round 3: `acertou`=1, `pronto`=1, `estado`=6.
- Round 2, second move with `jogada_igual`=0 → `errou`=1 the next cycle; `conta_jog` never pulses for that move.
- In `ESPERA`, no input for 10 cycles → `timeout`=1; variant with `jogada_valida` on the 10th cycle → move accepted, no timeout.
- `rst_n` low mid-`MOSTRA` → all outputs 0 immediately; `iniciar` in `MOSTRA` ignored; `iniciar` from `ERRO` restarts at `rodada`=0.
